ysyx_25040129_mem_arbiter: RTL and testbench

//  Two-master to one-master AXI4-lite-with-burst arbiter, directly upstream of the MMU.
//  IFU (read-only, burst fetch) and LSU (read/write, single beat) share one downstream port.
//  The downstream port drives the MMU in_* port.
//  One transaction is in flight at a time; grant is held until its response handshake completes.

---
 rtl/ysyx_25040129_mem_arbiter_pkg.sv | 32 +++
 rtl/ysyx_25040129_mem_arbiter_pick.sv | 22 ++
 rtl/ysyx_25040129_mem_arbiter.sv | 230 +++++++++++++++++++++++
 tb/tb_ysyx_25040129_mem_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25040129_mem_arbiter_pkg.sv
// Shared encodings for the IFU/LSU memory arbiter: FSM states, master ids, AXI response codes.
package ysyx_25040129_mem_arbiter_pkg;

   // Arbiter FSM states (3-bit state register)
   localparam logic [2:0] ARB_IDLE   = 3'd0;
   localparam logic [2:0] ARB_IFU_AR = 3'd1;
   localparam logic [2:0] ARB_IFU_R  = 3'd2;
   localparam logic [2:0] ARB_LSU_AR = 3'd3;
   localparam logic [2:0] ARB_LSU_R  = 3'd4;
   localparam logic [2:0] ARB_LSU_W  = 3'd5;
   localparam logic [2:0] ARB_LSU_B  = 3'd6;

   // Master ids, also used as bit positions in the picker request vector
   localparam logic ARB_M_IFU = 1'b0;
   localparam logic ARB_M_LSU = 1'b1;

   // AXI response codes
   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   // First state of the transaction granted to a master
   function automatic logic [2:0] arb_grant_state(input logic master, input logic lsu_write);
      if (master == ARB_M_IFU) begin
         return ARB_IFU_AR;
      end else if (lsu_write) begin
         return ARB_LSU_W;
      end else begin
         return ARB_LSU_AR;
      end
   endfunction

endpackage

// File: rtl/ysyx_25040129_mem_arbiter_pick.sv
// Two-way request picker: alternating (FAIR=1) or LSU-priority (FAIR=0) grant.
module ysyx_25040129_arb_pick
   import ysyx_25040129_mem_arbiter_pkg::*;
#(
   parameter int unsigned FAIR = 1
) (
   input  logic [1:0] req_i,
   input  logic       last_i,
   output logic       grant_o
);

   // Grant one requester; output is don't-care-but-defined when nobody requests
   always_comb begin
      grant_o = ARB_M_IFU;
      if (req_i[ARB_M_IFU] && req_i[ARB_M_LSU]) begin
         grant_o = (FAIR != 0) ? ~last_i : ARB_M_LSU;
      end else if (req_i[ARB_M_LSU]) begin
         grant_o = ARB_M_LSU;
      end
   end

endmodule

// File: rtl/ysyx_25040129_mem_arbiter.sv
// IFU/LSU to single downstream AXI4-lite(+burst) arbiter feeding the MMU.
// One transaction in flight; the grant is held until the response handshake completes.
module ysyx_25040129_mem_arbiter
   import ysyx_25040129_mem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned FAIR   = 1
) (
   input  logic                clk,
   input  logic                rst,
   // IFU read channels
   input  logic [ADDR_W-1:0]   ifu_araddr,
   input  logic [2:0]          ifu_arsize,
   input  logic [7:0]          ifu_arlen,
   input  logic [1:0]          ifu_arburst,
   input  logic                ifu_arvalid,
   output logic                ifu_arready,
   output logic [DATA_W-1:0]   ifu_rdata,
   output logic [1:0]          ifu_rresp,
   output logic                ifu_rlast,
   output logic                ifu_rvalid,
   input  logic                ifu_rready,
   // LSU read channels
   input  logic [ADDR_W-1:0]   lsu_araddr,
   input  logic [2:0]          lsu_arsize,
   input  logic [7:0]          lsu_arlen,
   input  logic [1:0]          lsu_arburst,
   input  logic                lsu_arvalid,
   output logic                lsu_arready,
   output logic [DATA_W-1:0]   lsu_rdata,
   output logic [1:0]          lsu_rresp,
   output logic                lsu_rlast,
   output logic                lsu_rvalid,
   input  logic                lsu_rready,
   // LSU write channels
   input  logic [ADDR_W-1:0]   lsu_awaddr,
   input  logic                lsu_awvalid,
   output logic                lsu_awready,
   input  logic [DATA_W-1:0]   lsu_wdata,
   input  logic [DATA_W/8-1:0] lsu_wstrb,
   input  logic                lsu_wvalid,
   output logic                lsu_wready,
   output logic [1:0]          lsu_bresp,
   output logic                lsu_bvalid,
   input  logic                lsu_bready,
   // Downstream (MMU in_*) port
   output logic [ADDR_W-1:0]   out_araddr,
   output logic [2:0]          out_arsize,
   output logic [7:0]          out_arlen,
   output logic [1:0]          out_arburst,
   output logic                out_arvalid,
   input  logic                out_arready,
   input  logic [DATA_W-1:0]   out_rdata,
   input  logic [1:0]          out_rresp,
   input  logic                out_rlast,
   input  logic                out_rvalid,
   output logic                out_rready,
   output logic [ADDR_W-1:0]   out_awaddr,
   output logic                out_awvalid,
   input  logic                out_awready,
   output logic [DATA_W-1:0]   out_wdata,
   output logic [DATA_W/8-1:0] out_wstrb,
   output logic                out_wvalid,
   input  logic                out_wready,
   input  logic [1:0]          out_bresp,
   input  logic                out_bvalid,
   output logic                out_bready
);

   logic [2:0] state_q, state_d;
   logic       last_q, last_d;
   logic       aw_done_q, aw_done_d;
   logic       w_done_q, w_done_d;

   logic       lsu_wr_req;
   logic [1:0] req;
   logic       grant;

   assign lsu_wr_req       = lsu_awvalid && lsu_wvalid;
   assign req[ARB_M_IFU]   = ifu_arvalid;
   assign req[ARB_M_LSU]   = lsu_wr_req || lsu_arvalid;

   ysyx_25040129_arb_pick #(
      .FAIR (FAIR)
   ) u_pick (
      .req_i   (req),
      .last_i  (last_q),
      .grant_o (grant)
   );

   // State, last winner and write-channel done flags
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ARB_IDLE;
         last_q    <= ARB_M_IFU;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
      end
   end

   // Next-state: arbitrate in IDLE, advance on forwarded handshakes elsewhere
   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      case (state_q)
         ARB_IDLE: begin
            if (|req) begin
               state_d = arb_grant_state(grant, lsu_wr_req);
            end
         end
         ARB_IFU_AR: if (out_arvalid && out_arready) state_d = ARB_IFU_R;
         ARB_LSU_AR: if (out_arvalid && out_arready) state_d = ARB_LSU_R;
         ARB_IFU_R: begin
            if (out_rvalid && out_rready && out_rlast) begin
               state_d = ARB_IDLE;
               last_d  = ARB_M_IFU;
            end
         end
         ARB_LSU_R: begin
            if (out_rvalid && out_rready && out_rlast) begin
               state_d = ARB_IDLE;
               last_d  = ARB_M_LSU;
            end
         end
         ARB_LSU_W: begin
            // AW and W may complete in either order; flags are cleared on exit
            aw_done_d = aw_done_q || (out_awvalid && out_awready);
            w_done_d  = w_done_q  || (out_wvalid && out_wready);
            if (aw_done_d && w_done_d) begin
               state_d   = ARB_LSU_B;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
            end
         end
         ARB_LSU_B: begin
            if (out_bvalid && out_bready) begin
               state_d = ARB_IDLE;
               last_d  = ARB_M_LSU;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   // Forwarding muxes: only the granted master's channels connect downstream
   always_comb begin
      out_araddr  = '0;
      out_arsize  = '0;
      out_arlen   = '0;
      out_arburst = '0;
      out_arvalid = 1'b0;
      ifu_arready = 1'b0;
      lsu_arready = 1'b0;
      ifu_rdata   = '0;
      ifu_rresp   = '0;
      ifu_rlast   = 1'b0;
      ifu_rvalid  = 1'b0;
      lsu_rdata   = '0;
      lsu_rresp   = '0;
      lsu_rlast   = 1'b0;
      lsu_rvalid  = 1'b0;
      out_rready  = 1'b0;
      out_awaddr  = '0;
      out_awvalid = 1'b0;
      lsu_awready = 1'b0;
      out_wdata   = '0;
      out_wstrb   = '0;
      out_wvalid  = 1'b0;
      lsu_wready  = 1'b0;
      lsu_bresp   = '0;
      lsu_bvalid  = 1'b0;
      out_bready  = 1'b0;
      case (state_q)
         ARB_IFU_AR: begin
            out_araddr  = ifu_araddr;
            out_arsize  = ifu_arsize;
            out_arlen   = ifu_arlen;
            out_arburst = ifu_arburst;
            out_arvalid = ifu_arvalid;
            ifu_arready = out_arready;
         end
         ARB_LSU_AR: begin
            out_araddr  = lsu_araddr;
            out_arsize  = lsu_arsize;
            out_arlen   = lsu_arlen;
            out_arburst = lsu_arburst;
            out_arvalid = lsu_arvalid;
            lsu_arready = out_arready;
         end
         ARB_IFU_R: begin
            ifu_rdata  = out_rdata;
            ifu_rresp  = out_rresp;
            ifu_rlast  = out_rlast;
            ifu_rvalid = out_rvalid;
            out_rready = ifu_rready;
         end
         ARB_LSU_R: begin
            lsu_rdata  = out_rdata;
            lsu_rresp  = out_rresp;
            lsu_rlast  = out_rlast;
            lsu_rvalid = out_rvalid;
            out_rready = lsu_rready;
         end
         ARB_LSU_W: begin
            out_awaddr  = lsu_awaddr;
            out_awvalid = lsu_awvalid && !aw_done_q;
            lsu_awready = out_awready && !aw_done_q;
            out_wdata   = lsu_wdata;
            out_wstrb   = lsu_wstrb;
            out_wvalid  = lsu_wvalid && !w_done_q;
            lsu_wready  = out_wready && !w_done_q;
         end
         ARB_LSU_B: begin
            lsu_bresp  = out_bresp;
            lsu_bvalid = out_bvalid;
            out_bready = lsu_bready;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ysyx_25040129_mem_arbiter.sv
// Directed self-checking bench for the IFU/LSU memory arbiter (FAIR=1).
module tb_ysyx_25040129_mem_arbiter;
   import ysyx_25040129_mem_arbiter_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] ifu_araddr;  logic [2:0] ifu_arsize; logic [7:0] ifu_arlen; logic [1:0] ifu_arburst;
   logic        ifu_arvalid, ifu_arready;
   logic [31:0] ifu_rdata;   logic [1:0] ifu_rresp;  logic ifu_rlast, ifu_rvalid, ifu_rready;
   logic [31:0] lsu_araddr;  logic [2:0] lsu_arsize; logic [7:0] lsu_arlen; logic [1:0] lsu_arburst;
   logic        lsu_arvalid, lsu_arready;
   logic [31:0] lsu_rdata;   logic [1:0] lsu_rresp;  logic lsu_rlast, lsu_rvalid, lsu_rready;
   logic [31:0] lsu_awaddr;  logic lsu_awvalid, lsu_awready;
   logic [31:0] lsu_wdata;   logic [3:0] lsu_wstrb;  logic lsu_wvalid, lsu_wready;
   logic [1:0]  lsu_bresp;   logic lsu_bvalid, lsu_bready;
   logic [31:0] out_araddr;  logic [2:0] out_arsize; logic [7:0] out_arlen; logic [1:0] out_arburst;
   logic        out_arvalid, out_arready;
   logic [31:0] out_rdata;   logic [1:0] out_rresp;  logic out_rlast, out_rvalid, out_rready;
   logic [31:0] out_awaddr;  logic out_awvalid, out_awready;
   logic [31:0] out_wdata;   logic [3:0] out_wstrb;  logic out_wvalid, out_wready;
   logic [1:0]  out_bresp;   logic out_bvalid, out_bready;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ysyx_25040129_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .FAIR(1)) dut (
      .clk(clk), .rst(rst),
      .ifu_araddr(ifu_araddr), .ifu_arsize(ifu_arsize), .ifu_arlen(ifu_arlen), .ifu_arburst(ifu_arburst),
      .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
      .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rlast(ifu_rlast), .ifu_rvalid(ifu_rvalid),
      .ifu_rready(ifu_rready),
      .lsu_araddr(lsu_araddr), .lsu_arsize(lsu_arsize), .lsu_arlen(lsu_arlen), .lsu_arburst(lsu_arburst),
      .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
      .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rlast(lsu_rlast), .lsu_rvalid(lsu_rvalid),
      .lsu_rready(lsu_rready),
      .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready),
      .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready),
      .lsu_bresp(lsu_bresp), .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
      .out_araddr(out_araddr), .out_arsize(out_arsize), .out_arlen(out_arlen), .out_arburst(out_arburst),
      .out_arvalid(out_arvalid), .out_arready(out_arready),
      .out_rdata(out_rdata), .out_rresp(out_rresp), .out_rlast(out_rlast), .out_rvalid(out_rvalid),
      .out_rready(out_rready),
      .out_awaddr(out_awaddr), .out_awvalid(out_awvalid), .out_awready(out_awready),
      .out_wdata(out_wdata), .out_wstrb(out_wstrb), .out_wvalid(out_wvalid), .out_wready(out_wready),
      .out_bresp(out_bresp), .out_bvalid(out_bvalid), .out_bready(out_bready)
   );

   task automatic clear_inputs();
      ifu_araddr = '0; ifu_arsize = '0; ifu_arlen = '0; ifu_arburst = '0; ifu_arvalid = 0; ifu_rready = 0;
      lsu_araddr = '0; lsu_arsize = '0; lsu_arlen = '0; lsu_arburst = '0; lsu_arvalid = 0; lsu_rready = 0;
      lsu_awaddr = '0; lsu_awvalid = 0; lsu_wdata = '0; lsu_wstrb = '0; lsu_wvalid = 0; lsu_bready = 0;
      out_arready = 0; out_rdata = '0; out_rresp = '0; out_rlast = 0; out_rvalid = 0;
      out_awready = 0; out_wready = 0; out_bresp = '0; out_bvalid = 0;
   endtask

   task automatic test_reset();
      clear_inputs();
      #3 rst = 1'b0;
      ifu_araddr = 32'h1234_5678; ifu_arvalid = 1; out_rvalid = 1; out_arready = 1; lsu_bready = 1;
      #1;
      checks++; if (out_arvalid !== 1'b0) begin failures++; $display("FAIL reset_out_arvalid got=%b exp=0", out_arvalid); end
      checks++; if (out_araddr !== 32'h0) begin failures++; $display("FAIL reset_out_araddr got=%h exp=0", out_araddr); end
      checks++; if ({ifu_arready, lsu_arready, ifu_rvalid, lsu_rvalid, out_rready} !== 5'b0) begin
         failures++; $display("FAIL reset_handshakes got=%b exp=00000", {ifu_arready, lsu_arready, ifu_rvalid, lsu_rvalid, out_rready}); end
      checks++; if ({out_awvalid, out_wvalid, lsu_awready, lsu_wready, lsu_bvalid, out_bready} !== 6'b0) begin
         failures++; $display("FAIL reset_write_side got=%b exp=000000", {out_awvalid, out_wvalid, lsu_awready, lsu_wready, lsu_bvalid, out_bready}); end
      @(negedge clk); @(negedge clk);
      clear_inputs();
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_ifu_burst();
      ifu_araddr = 32'h8000_0000; ifu_arlen = 8'd3; ifu_arsize = 3'd2; ifu_arburst = 2'b01; ifu_arvalid = 1;
      #1;
      checks++; if (out_arvalid !== 1'b0) begin failures++; $display("FAIL ifu_ar_latency got=%b exp=0", out_arvalid); end
      @(negedge clk); #1;
      checks++; if (out_arvalid !== 1'b1) begin failures++; $display("FAIL ifu_ar_fwd got=%b exp=1", out_arvalid); end
      checks++; if ({out_araddr, out_arlen, out_arburst} !== {32'h8000_0000, 8'd3, 2'b01}) begin
         failures++; $display("FAIL ifu_ar_payload got=%h/%0d/%b exp=80000000/3/01", out_araddr, out_arlen, out_arburst); end
      out_arready = 1; #1;
      checks++; if ({ifu_arready, lsu_arready} !== 2'b10) begin failures++; $display("FAIL ifu_arready got=%b exp=10", {ifu_arready, lsu_arready}); end
      @(negedge clk);
      ifu_arvalid = 0; out_arready = 0; ifu_rready = 1;
      for (int i = 0; i < 4; i++) begin
         out_rvalid = 1; out_rdata = 32'h1000_0000 + i; out_rlast = (i == 3); out_rresp = OKAY;
         #1;
         checks++; if ({ifu_rvalid, lsu_rvalid, out_rready} !== 3'b101) begin
            failures++; $display("FAIL ifu_beat%0d_valid got=%b exp=101", i, {ifu_rvalid, lsu_rvalid, out_rready}); end
         checks++; if (ifu_rdata !== 32'h1000_0000 + i || ifu_rlast !== (i == 3)) begin
            failures++; $display("FAIL ifu_beat%0d_data got=%h last=%b exp=%h last=%b", i, ifu_rdata, ifu_rlast, 32'h1000_0000 + i, (i == 3)); end
         @(negedge clk);
      end
      out_rvalid = 0; out_rlast = 0; ifu_rready = 0; #1;
      checks++; if ({ifu_rvalid, out_rready, out_arvalid} !== 3'b000) begin
         failures++; $display("FAIL ifu_back_idle got=%b exp=000", {ifu_rvalid, out_rready, out_arvalid}); end
      @(negedge clk);
   endtask

   task automatic test_fair_both();
      ifu_araddr = 32'h8000_0040; ifu_arlen = 8'd0; ifu_arvalid = 1;
      lsu_araddr = 32'h8000_0200; lsu_arlen = 8'd0; lsu_arsize = 3'd2; lsu_arvalid = 1;
      #1;
      checks++; if (out_arvalid !== 1'b0) begin failures++; $display("FAIL fair_latency got=%b exp=0", out_arvalid); end
      @(negedge clk); #1;
      checks++; if (out_arvalid !== 1'b1 || out_araddr !== 32'h8000_0200) begin
         failures++; $display("FAIL fair_first_lsu got=%b/%h exp=1/80000200", out_arvalid, out_araddr); end
      out_arready = 1; #1;
      checks++; if ({ifu_arready, lsu_arready} !== 2'b01) begin failures++; $display("FAIL fair_lsu_arready got=%b exp=01", {ifu_arready, lsu_arready}); end
      @(negedge clk);
      lsu_arvalid = 0; out_arready = 0; lsu_rready = 1; ifu_rready = 1;
      out_rvalid = 1; out_rlast = 1; out_rdata = 32'hCAFE_0001; #1;
      checks++; if ({lsu_rvalid, ifu_rvalid} !== 2'b10 || lsu_rdata !== 32'hCAFE_0001) begin
         failures++; $display("FAIL fair_lsu_r got=%b/%h exp=10/cafe0001", {lsu_rvalid, ifu_rvalid}, lsu_rdata); end
      @(negedge clk);
      out_rvalid = 0; out_rlast = 0; #1;
      checks++; if (out_arvalid !== 1'b0) begin failures++; $display("FAIL fair_idle_gap got=%b exp=0", out_arvalid); end
      @(negedge clk); #1;
      checks++; if (out_arvalid !== 1'b1 || out_araddr !== 32'h8000_0040) begin
         failures++; $display("FAIL fair_second_ifu got=%b/%h exp=1/80000040", out_arvalid, out_araddr); end
      out_arready = 1;
      @(negedge clk);
      ifu_arvalid = 0; out_arready = 0;
      out_rvalid = 1; out_rlast = 1; out_rdata = 32'hCAFE_0002; #1;
      checks++; if ({lsu_rvalid, ifu_rvalid} !== 2'b01 || ifu_rdata !== 32'hCAFE_0002) begin
         failures++; $display("FAIL fair_ifu_r got=%b/%h exp=01/cafe0002", {lsu_rvalid, ifu_rvalid}, ifu_rdata); end
      @(negedge clk);
      clear_inputs();
      @(negedge clk);
   endtask

   task automatic test_lsu_write();
      lsu_awaddr = 32'h8000_0100; lsu_awvalid = 1; lsu_wdata = 32'hDEAD_BEEF; lsu_wstrb = 4'hF; lsu_wvalid = 1;
      #1;
      checks++; if (out_awvalid !== 1'b0) begin failures++; $display("FAIL wr_latency got=%b exp=0", out_awvalid); end
      @(negedge clk); #1;
      checks++; if ({out_awvalid, out_wvalid} !== 2'b11 || out_awaddr !== 32'h8000_0100) begin
         failures++; $display("FAIL wr_fwd got=%b/%h exp=11/80000100", {out_awvalid, out_wvalid}, out_awaddr); end
      checks++; if (out_wdata !== 32'hDEAD_BEEF || out_wstrb !== 4'hF) begin
         failures++; $display("FAIL wr_payload got=%h/%h exp=deadbeef/f", out_wdata, out_wstrb); end
      out_awready = 1; #1;
      checks++; if ({lsu_awready, lsu_wready} !== 2'b10) begin failures++; $display("FAIL wr_awready got=%b exp=10", {lsu_awready, lsu_wready}); end
      @(negedge clk);
      out_awready = 0; #1;
      // LSU still holds awvalid here; the done flag must mask it
      checks++; if ({out_awvalid, out_wvalid} !== 2'b01) begin
         failures++; $display("FAIL wr_aw_dropped got=%b exp=01", {out_awvalid, out_wvalid}); end
      @(negedge clk);
      out_wready = 1; #1;
      checks++; if ({lsu_awready, lsu_wready} !== 2'b01) begin failures++; $display("FAIL wr_wready got=%b exp=01", {lsu_awready, lsu_wready}); end
      @(negedge clk);
      lsu_awvalid = 0; lsu_wvalid = 0; out_wready = 0; lsu_bready = 1; #1;
      checks++; if ({lsu_bvalid, out_wvalid, out_bready} !== 3'b001) begin
         failures++; $display("FAIL wr_b_wait got=%b exp=001", {lsu_bvalid, out_wvalid, out_bready}); end
      out_bvalid = 1; out_bresp = OKAY; #1;
      checks++; if (lsu_bvalid !== 1'b1 || lsu_bresp !== OKAY) begin
         failures++; $display("FAIL wr_b_fwd got=%b/%b exp=1/00", lsu_bvalid, lsu_bresp); end
      @(negedge clk);
      out_bvalid = 0; #1;
      checks++; if ({lsu_bvalid, out_bready} !== 2'b00) begin failures++; $display("FAIL wr_back_idle got=%b exp=00", {lsu_bvalid, out_bready}); end
      clear_inputs();
      @(negedge clk);
   endtask

   task automatic test_ifu_wait_during_b();
      lsu_awaddr = 32'h8000_0300; lsu_awvalid = 1; lsu_wdata = 32'h0000_00AA; lsu_wstrb = 4'h1; lsu_wvalid = 1;
      @(negedge clk);
      out_awready = 1; out_wready = 1;
      @(negedge clk);
      lsu_awvalid = 0; lsu_wvalid = 0; out_awready = 0; out_wready = 0; lsu_bready = 1;
      ifu_araddr = 32'h8000_0080; ifu_arlen = 8'd0; ifu_arvalid = 1; out_arready = 1;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++; if ({ifu_arready, out_arvalid, lsu_bvalid} !== 3'b000) begin
            failures++; $display("FAIL bwait_cycle%0d got=%b exp=000", i, {ifu_arready, out_arvalid, lsu_bvalid}); end
         @(negedge clk);
      end
      out_bvalid = 1; out_bresp = OKAY;
      @(negedge clk);
      out_bvalid = 0; #1;
      checks++; if ({ifu_arready, out_arvalid} !== 2'b00) begin failures++; $display("FAIL bwait_idle got=%b exp=00", {ifu_arready, out_arvalid}); end
      @(negedge clk); #1;
      checks++; if ({ifu_arready, out_arvalid} !== 2'b11 || out_araddr !== 32'h8000_0080) begin
         failures++; $display("FAIL bwait_ifu_grant got=%b/%h exp=11/80000080", {ifu_arready, out_arvalid}, out_araddr); end
      @(negedge clk);
      ifu_arvalid = 0; out_arready = 0; ifu_rready = 1; out_rvalid = 1; out_rlast = 1;
      @(negedge clk);
      clear_inputs();
      @(negedge clk);
   endtask

   task automatic test_slverr();
      lsu_araddr = 32'h0000_0000; lsu_arlen = 8'd0; lsu_arsize = 3'd2; lsu_arvalid = 1;
      @(negedge clk);
      out_arready = 1;
      @(negedge clk);
      lsu_arvalid = 0; out_arready = 0; lsu_rready = 1;
      out_rvalid = 1; out_rlast = 1; out_rresp = SLVERR; out_rdata = 32'h0; #1;
      checks++; if (lsu_rvalid !== 1'b1 || lsu_rresp !== 2'b10) begin
         failures++; $display("FAIL slverr_resp got=%b/%b exp=1/10", lsu_rvalid, lsu_rresp); end
      @(negedge clk);
      out_rvalid = 0; out_rlast = 0; #1;
      checks++; if ({lsu_rvalid, out_rready, out_arvalid} !== 3'b000) begin
         failures++; $display("FAIL slverr_idle got=%b exp=000", {lsu_rvalid, out_rready, out_arvalid}); end
      clear_inputs();
      @(negedge clk);
   endtask

   task automatic test_reset_mid_burst();
      ifu_araddr = 32'h8000_1000; ifu_arlen = 8'd3; ifu_arburst = 2'b01; ifu_arvalid = 1;
      @(negedge clk);
      out_arready = 1;
      @(negedge clk);
      ifu_arvalid = 0; out_arready = 0; ifu_rready = 1; out_rvalid = 1; out_rdata = 32'h1;
      @(negedge clk);
      out_rdata = 32'h2; #1;
      checks++; if (ifu_rvalid !== 1'b1) begin failures++; $display("FAIL rstmid_beat2 got=%b exp=1", ifu_rvalid); end
      rst = 1'b0; #1;
      checks++; if ({ifu_rvalid, out_rready, ifu_arready, out_arvalid, lsu_rvalid} !== 5'b0) begin
         failures++; $display("FAIL rstmid_outputs got=%b exp=00000", {ifu_rvalid, out_rready, ifu_arready, out_arvalid, lsu_rvalid}); end
      @(negedge clk);
      clear_inputs();
      rst = 1'b1;
      @(negedge clk);
      ifu_araddr = 32'h8000_2000; ifu_arlen = 8'd0; ifu_arvalid = 1; #1;
      checks++; if (out_arvalid !== 1'b0) begin failures++; $display("FAIL rstmid_idle got=%b exp=0", out_arvalid); end
      @(negedge clk); #1;
      checks++; if (out_arvalid !== 1'b1 || out_araddr !== 32'h8000_2000) begin
         failures++; $display("FAIL rstmid_regrant got=%b/%h exp=1/80002000", out_arvalid, out_araddr); end
      clear_inputs();
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_ifu_burst();
      test_fair_both();
      test_lsu_write();
      test_ifu_wait_during_b();
      test_slverr();
      test_reset_mid_burst();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
